// File: rtl/demux_1to2_if.sv
// Bus bundle for the 1:2 serial demultiplexer: serial input strobe plus
// one valid/ready word port per output channel.
interface demux_1to2_if #(
   parameter int WIDTH = 8
);

   logic             y;
   logic             se;
   logic             en;

   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic             a_ovf;

   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;
   logic             b_ovf;

   // Master is the upstream source and downstream consumer; slave is the demux.
   modport master (
      output y, se, en, a_ready, b_ready,
      input  a_data, a_valid, a_ovf, b_data, b_valid, b_ovf
   );

   modport slave (
      input  y, se, en, a_ready, b_ready,
      output a_data, a_valid, a_ovf, b_data, b_valid, b_ovf
   );

endinterface

// File: rtl/demux_1to2.sv
// 1:2 serial demultiplexer: steers strobed serial bits into one of two
// LSB-first word assemblers, each with a one-deep valid/ready output and sticky overflow.
module demux_1to2 #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   demux_1to2_if.slave   bus
);

   localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   for (genvar c = 0; c < 2; c++) begin : chan
      logic             ready;
      logic             accept;
      logic             complete;
      logic             transfer;
      logic [WIDTH-1:0] word;
      logic [WIDTH-1:0] shreg;
      logic [CW-1:0]    cnt;
      logic [WIDTH-1:0] data_q;
      logic             valid_q;
      logic             ovf_q;

      if (c == 0) begin : sel_a
         assign ready = bus.a_ready;
      end else begin : sel_b
         assign ready = bus.b_ready;
      end

      // New bits enter at the MSB so the first bit ends up at bit 0 after WIDTH shifts.
      assign accept   = bus.en && (bus.se == 1'(c));
      assign word     = {bus.y, shreg[WIDTH-1:1]};
      assign complete = accept && (cnt == LAST);
      assign transfer = valid_q && ready;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            shreg <= '0;
            cnt   <= '0;
         end else if (accept) begin
            shreg <= word;
            cnt   <= complete ? '0 : cnt + 1'b1;
         end
      end

      // A completed word is kept only if the holding slot is empty or drains on this edge.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
         end else if (complete) begin
            if (!valid_q || transfer) begin
               data_q  <= word;
               valid_q <= 1'b1;
            end else begin
               ovf_q   <= 1'b1;
            end
         end else if (transfer) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.a_data  = chan[0].data_q;
   assign bus.a_valid = chan[0].valid_q;
   assign bus.a_ovf   = chan[0].ovf_q;
   assign bus.b_data  = chan[1].data_q;
   assign bus.b_valid = chan[1].valid_q;
   assign bus.b_ovf   = chan[1].ovf_q;

endmodule

// File: tb/tb_demux_1to2.sv
// Self-checking bench for demux_1to2 (WIDTH=8): scoreboard of expected words
// per channel, plus direct checks of valid/overflow and asynchronous reset.
module tb_demux_1to2;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [WIDTH-1:0] exp_a[$];
   logic [WIDTH-1:0] exp_b[$];

   demux_1to2_if #(.WIDTH(WIDTH)) bus ();

   demux_1to2 #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of strobe/select/data at the falling edge.
   task automatic applyStimulus(input logic en_v, input logic se_v, input logic y_v);
      @(negedge clk);
      bus.en = en_v;
      bus.se = se_v;
      bus.y  = y_v;
   endtask

   task automatic settle();
      @(negedge clk);
      bus.en = 1'b0;
   endtask

   task automatic sendWord(input int ch, input logic [WIDTH-1:0] word, input bit gaps,
                           input bit push, input bit ready_on_last);
      for (int i = 0; i < WIDTH; i++) begin
         if (gaps) begin
            repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'($urandom), 1'($urandom));
         end
         applyStimulus(1'b1, 1'(ch), word[i]);
         if (ready_on_last && i == WIDTH - 1) begin
            if (ch == 0) bus.a_ready = 1'b1;
            else         bus.b_ready = 1'b1;
         end
      end
      if (push) begin
         if (ch == 0) exp_a.push_back(word);
         else         exp_b.push_back(word);
      end
      settle();
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
   endtask

   task automatic popCheck(input int ch);
      logic [WIDTH-1:0] exp_word;
      if (ch == 0) begin
         exp_word = (exp_a.size() > 0) ? exp_a.pop_front() : 'x;
         checkOutput("a_valid", 32'(bus.a_valid), 32'd1);
         checkOutput("a_data", 32'(bus.a_data), 32'(exp_word));
      end else begin
         exp_word = (exp_b.size() > 0) ? exp_b.pop_front() : 'x;
         checkOutput("b_valid", 32'(bus.b_valid), 32'd1);
         checkOutput("b_data", 32'(bus.b_data), 32'(exp_word));
      end
   endtask

   task automatic consume(input int ch);
      @(negedge clk);
      bus.en = 1'b0;
      if (ch == 0) bus.a_ready = 1'b1;
      else         bus.b_ready = 1'b1;
      @(negedge clk);
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
      if (ch == 0) checkOutput("a_valid_drain", 32'(bus.a_valid), 32'd0);
      else         checkOutput("b_valid_drain", 32'(bus.b_valid), 32'd0);
   endtask

   task automatic resetPulse(input string tag);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput({tag, "_a_data"},  32'(bus.a_data),  32'd0);
      checkOutput({tag, "_a_valid"}, 32'(bus.a_valid), 32'd0);
      checkOutput({tag, "_a_ovf"},   32'(bus.a_ovf),   32'd0);
      checkOutput({tag, "_b_data"},  32'(bus.b_data),  32'd0);
      checkOutput({tag, "_b_valid"}, 32'(bus.b_valid), 32'd0);
      checkOutput({tag, "_b_ovf"},   32'(bus.b_ovf),   32'd0);
      #1 rst = 1'b0;
      exp_a.delete();
      exp_b.delete();
   endtask

   initial begin
      logic [WIDTH-1:0] wa;
      logic [WIDTH-1:0] wb;
      bus.y = 1'b0; bus.se = 1'b0; bus.en = 1'b0;
      bus.a_ready = 1'b0; bus.b_ready = 1'b0;

      resetPulse("init");

      // Single word on channel a with no consumer.
      sendWord(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      popCheck(0);
      checkOutput("single_b_valid", 32'(bus.b_valid), 32'd0);
      checkOutput("single_a_ovf",   32'(bus.a_ovf),   32'd0);
      consume(0);

      // Interleaved bits: even cycles to a, odd cycles to b.
      wa = 8'h3C;
      wb = 8'hC3;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         if (i % 2 == 0) applyStimulus(1'b1, 1'b0, wa[i / 2]);
         else            applyStimulus(1'b1, 1'b1, wb[i / 2]);
      end
      exp_a.push_back(wa);
      exp_b.push_back(wb);
      settle();
      popCheck(0);
      popCheck(1);
      consume(0);
      consume(1);

      // Same word with idle strobes carrying random y/se in between.
      sendWord(0, 8'hA5, 1'b1, 1'b1, 1'b0);
      popCheck(0);
      checkOutput("gaps_b_valid", 32'(bus.b_valid), 32'd0);
      checkOutput("gaps_a_ovf",   32'(bus.a_ovf),   32'd0);
      consume(0);

      // Overflow: second word dropped while first is still held.
      sendWord(0, 8'h11, 1'b0, 1'b1, 1'b0);
      sendWord(0, 8'h22, 1'b0, 1'b0, 1'b0);
      popCheck(0);
      checkOutput("ovf_a_ovf", 32'(bus.a_ovf), 32'd1);
      checkOutput("ovf_b_ovf", 32'(bus.b_ovf), 32'd0);
      consume(0);
      checkOutput("ovf_sticky", 32'(bus.a_ovf), 32'd1);
      repeat (2) settle();
      checkOutput("ovf_sticky_later", 32'(bus.a_ovf), 32'd1);

      resetPulse("clr");

      // Completion on the same edge as a transfer replaces the word cleanly.
      sendWord(0, 8'h11, 1'b0, 1'b1, 1'b0);
      popCheck(0);
      sendWord(0, 8'h22, 1'b0, 1'b1, 1'b1);
      popCheck(0);
      checkOutput("simul_a_ovf", 32'(bus.a_ovf), 32'd0);
      checkOutput("simul_b_valid", 32'(bus.b_valid), 32'd0);

      // Reset after a partial word on b; a still holds 0x22 going in.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      settle();
      resetPulse("mid");
      sendWord(1, 8'h5A, 1'b0, 1'b1, 1'b0);
      popCheck(1);
      checkOutput("mid_b_ovf", 32'(bus.b_ovf), 32'd0);
      checkOutput("mid_a_valid", 32'(bus.a_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_1to2.md
DEMUX_1TO2 -- requirements
Module: demux_1to2

Interface
REQ-001 Parameter: WIDTH, default 8, word width per output channel (WIDTH >= 2).
REQ-002 clk  input  1  rising-edge clock; all state is updated on it.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 y  input  1  serial data bit from the upstream 2:1 mux output.
REQ-005 se  input  1  channel select: 0 = channel a, 1 = channel b.
REQ-006 en  input  1  bit strobe: y and se are sampled only when en = 1.
REQ-007 a_data  output  WIDTH  channel a assembled word.
REQ-008 a_valid  output  1  a_data holds an unconsumed word.
REQ-009 a_ready  input  1  consumer accepts channel a word.
REQ-010 a_ovf  output  1  sticky flag: a channel a word was dropped.
REQ-011 b_data, b_valid, b_ready, b_ovf: same as REQ-007..REQ-010, for channel b.

Function
REQ-012 Each channel shall have:
  - a WIDTH-bit shift register;
  - a bit counter, 0..WIDTH-1;
  - a WIDTH-bit holding register driving x_data;
  - a valid flag driving x_valid;
  - a sticky overflow flag driving x_ovf.
REQ-013 On an edge with en=1, bit y shall be shifted into the shift register of the channel selected by se, LSB first: the first bit received lands in bit 0 of the completed word.
REQ-014 The unselected channel's shift register and counter shall be unchanged.
REQ-015 On an edge with en=0, no shift register or counter shall change, regardless of y and se.
REQ-016 The bit counter of the selected channel shall increment by 1 per accepted bit.
REQ-017 On the edge accepting the bit while the counter = WIDTH-1, the word shall complete and the counter shall wrap to 0 on that same edge.
REQ-018 Word complete, x_valid=0: the word shall load into x_data and x_valid shall go to 1 on that same edge; x_valid is therefore visible the cycle after the final bit's edge (latency 1).
REQ-019 Transfer: a transfer occurs on an edge where x_valid=1 and x_ready=1; x_valid shall then clear unless REQ-020 applies.
REQ-020 Word complete on the same edge as a transfer: the new word shall load into x_data, x_valid shall stay 1, and x_ovf shall not change.
REQ-021 Word complete, x_valid=1, x_ready=0: the new word shall be discarded, x_data shall be unchanged, x_ovf shall go to 1, and the counter shall still wrap to 0.
REQ-022 x_ovf shall remain 1 until reset.
REQ-023 While x_valid=1 and x_ready=0, x_data shall be held stable.
REQ-024 x_ready is ignored while x_valid=0.
REQ-025 Channels a and b shall operate independently: handshakes, completions and overflows on one channel shall never affect the other.
REQ-026 Only one channel can receive a bit per cycle (selected by se), so simultaneous completion on both channels cannot occur.
REQ-027 All outputs shall be registered; no combinational path from any input to any output.

Reset
REQ-028 While rst=1, asynchronously and regardless of clk:
  - all shift registers, counters and holding registers = 0;
  - a_data = b_data = 0;
  - a_valid = b_valid = 0;
  - a_ovf = b_ovf = 0.
REQ-029 Reset mid-word: partially received bits shall be discarded, and the next accepted bit after rst deasserts is bit 0 of a new word.
REQ-030 Normal operation shall resume on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-031 Single word on a: 0xA5 LSB first, se=0, en=1 for 8 cycles, a_ready=0.
  -> a_valid=1 and a_data=0xA5 in the cycle after the 8th edge.
  -> b_valid stays 0; a_ovf stays 0.
REQ-032 Interleaved: se alternates 0/1 each cycle over 16 cycles, carrying 0x3C to a and 0xC3 to b.
  -> a_data=0x3C and b_data=0xC3, both valid.
REQ-033 Strobe gaps: repeat REQ-031 with en=0 cycles inserted between bits while y and se toggle randomly.
  -> result identical to REQ-031.
REQ-034 Overflow: a_ready=0; send 0x11 then 0x22 on a.
  -> a_data stays 0x11 and a_ovf=1.
  -> then a_ready=1 for one edge: a_valid=0, a_ovf still 1.
REQ-035 Simultaneous: a_valid=1 holding 0x11; assert a_ready on the same edge as 0x22 completes.
  -> a_data=0x22, a_valid=1, a_ovf=0.
REQ-036 Reset mid-word: send 4 bits on b, then pulse rst between clock edges.
  -> all outputs are 0 immediately.
  -> next 8 bits of 0x5A produce b_data=0x5A.
